// File: rtl/rns_pkg.sv
// Shared constants and range/correction helpers for the RNS modular-reduction datapath.
package rns_pkg;
  localparam int RNS_W    = 8;
  localparam int RNS_M    = 251;
  localparam int RNS_MAXW = 31;

  // Raw add/sub results are zero-extended into this container so helpers stay width-agnostic.
  typedef logic [RNS_MAXW:0] rns_raw_t;

  function automatic logic rns_range_err(input rns_raw_t v, input logic sub,
                                         input int w, input int m);
    logic [63:0] vv;
    logic [63:0] span;
    vv   = 64'(v);
    span = 64'd1 << (w + 1);
    if (!sub) return vv > 64'(2 * m - 2);
    if (vv >= (span >> 1)) return vv < (span - 64'(m - 1));
    return vv > 64'(m - 1);
  endfunction

  function automatic logic rns_needs_fix(input rns_raw_t v, input logic sub,
                                         input int w, input int m);
    if (sub) return ((64'(v) >> w) & 64'd1) != 64'd0;
    return 64'(v) >= 64'(m);
  endfunction

  // Only the low W bits are meaningful; the add/sub wraps into the residue range.
  function automatic rns_raw_t rns_correct(input rns_raw_t v, input logic sub, input int m);
    return sub ? (v + rns_raw_t'(m)) : (v - rns_raw_t'(m));
  endfunction
endpackage

// File: rtl/rns_pipe_reg.sv
// Single-entry valid/ready register slice; accepts whenever empty or draining.
module rns_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready  = !vld_q || out_ready;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_ready) begin
      vld_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/rns_mod_reduce.sv
// Two-stage elastic reduction of a raw add/sub result into [0, M-1].
// Define RNS_MOD_REDUCE_STATS_EN to add a saturating err_cnt output.
module rns_mod_reduce
  import rns_pkg::*;
#(
  parameter int W = RNS_W,
  parameter int M = RNS_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [W:0]   in_val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err
`ifdef RNS_MOD_REDUCE_STATS_EN
  ,
  output logic [15:0]  err_cnt
`endif
);
  localparam int S1W = W + 4;
  localparam int S2W = W + 1;

  if (W < 1 || W > 30 || M < 2 || M >= (1 << W)) begin : g_param_chk
    $error("rns_mod_reduce: need 2 <= M < 2**W and 1 <= W <= 30");
  end

  logic [S1W-1:0] s1_in, s1_out;
  logic [S2W-1:0] s2_in, s2_out;
  logic           s1_vld, s2_rdy;
  logic           s1_sub, s1_fix, s1_err;
  logic [W:0]     s1_val;
  logic [W-1:0]   s2_res;

  // Flags are resolved before S1 so S2 only has one add/sub on its path.
  always_comb begin
    s1_in = {in_sub,
             rns_needs_fix(rns_raw_t'(in_val), in_sub, W, M),
             rns_range_err(rns_raw_t'(in_val), in_sub, W, M),
             in_val};
  end

  rns_pipe_reg #(.DW(S1W)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_vld),
    .out_ready(s2_rdy),
    .out_data (s1_out)
  );

  assign {s1_sub, s1_fix, s1_err, s1_val} = s1_out;

  // Out-of-range inputs pass their low bits through untouched.
  always_comb begin
    s2_res = s1_val[W-1:0];
    if (!s1_err && s1_fix) s2_res = W'(rns_correct(rns_raw_t'(s1_val), s1_sub, M));
    s2_in = {s1_err, s2_res};
  end

  rns_pipe_reg #(.DW(S2W)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_vld),
    .in_ready (s2_rdy),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_out)
  );

  assign {out_err, out_res} = s2_out;

`ifdef RNS_MOD_REDUCE_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && out_err && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule
